// File: rtl/risc_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package risc_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RISC_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fq_entry_t;

endpackage

// File: rtl/risc_fetch_fifo.sv
// In-order fetch entry storage: entries are reserved at grant, filled on response, popped by IF/ID.
module risc_fetch_fifo
    import risc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             reserve,
    input  logic [XLEN-1:0]  reserve_pc,
    input  logic             fill,
    input  logic [XLEN-1:0]  fill_instr,
    input  logic             pop,
    output fq_entry_t        head_c,
    output logic             fill_at_head_c,
    output logic [PTR_W-1:0] pending_c,
    output logic [PTR_W-1:0] count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    fq_entry_t        mem_q [DEPTH];
    fq_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] rsv_q, rsv_d;
    logic [PTR_W-1:0] fill_q, fill_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] cnt_q, cnt_d;

    // Pop is applied after fill so a same-cycle fill+pop never leaves the entry marked filled.
    always_comb begin
        mem_d  = mem_q;
        rsv_d  = rsv_q;
        fill_d = fill_q;
        head_d = head_q;
        cnt_d  = cnt_q;
        if (clear) begin
            rsv_d  = '0;
            fill_d = '0;
            head_d = '0;
            cnt_d  = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_d[i].filled = 1'b0;
            end
        end else begin
            if (reserve) begin
                mem_d[rsv_q[IDX_W-1:0]].pc     = reserve_pc;
                mem_d[rsv_q[IDX_W-1:0]].filled = 1'b0;
                rsv_d = rsv_q + PTR_W'(1);
            end
            if (fill) begin
                mem_d[fill_q[IDX_W-1:0]].instr  = fill_instr;
                mem_d[fill_q[IDX_W-1:0]].filled = 1'b1;
                fill_d = fill_q + PTR_W'(1);
            end
            if (pop) begin
                mem_d[head_q[IDX_W-1:0]].filled = 1'b0;
                head_d = head_q + PTR_W'(1);
            end
            cnt_d = cnt_q + PTR_W'(reserve) - PTR_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rsv_q  <= '0;
            fill_q <= '0;
            head_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            rsv_q  <= rsv_d;
            fill_q <= fill_d;
            head_q <= head_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_c         = mem_q[head_q[IDX_W-1:0]];
    assign fill_at_head_c = (fill_q == head_q);
    assign pending_c      = rsv_q - fill_q;
    assign count          = cnt_q;

endmodule

// File: rtl/risc_fetch_queue.sv
// Instruction-fetch stage: memory request issue, response queueing, drop tracking and IF/ID register.
// Optional RISC_FETCH_BYPASS_EN forwards a response that lands on the queue head straight into IF/ID.
module risc_fetch_queue
    import risc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PCF,
    output logic            FetchAdvF,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemGnt,
    input  logic            ImemRvalid,
    input  logic [XLEN-1:0] ImemRdata,
    input  logic            StallD,
    input  logic            FlushD,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned DROP_W = CNT_W + 2;

    fq_entry_t        head;
    logic             fill_at_head;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] count;

    logic             req_c, grant_c, fill_c, bypass_c, head_rdy_c, pop_c;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  instr_q, instr_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pcp4_q, pcp4_d;

    assign req_c    = !rst && !FlushD && (count < CNT_W'(DEPTH));
    assign grant_c  = req_c && ImemGnt;
    assign fill_c   = ImemRvalid && !FlushD && (drop_q == '0);

    assign ImemReq   = req_c;
    assign ImemAddr  = PCF;
    assign FetchAdvF = !rst && (grant_c || FlushD);

`ifdef RISC_FETCH_BYPASS_EN
    assign bypass_c = fill_c && fill_at_head && !StallD;
`else
    assign bypass_c = 1'b0;
`endif

    // Fills land in grant order, so a filled head always sits behind the fill pointer.
    assign head_rdy_c = head.filled && !fill_at_head;
    assign pop_c      = !FlushD && !StallD && (bypass_c || head_rdy_c);

    risc_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .clear          (FlushD),
        .reserve        (grant_c),
        .reserve_pc     (PCF),
        .fill           (fill_c),
        .fill_instr     (ImemRdata),
        .pop            (pop_c),
        .head_c         (head),
        .fill_at_head_c (fill_at_head),
        .pending_c      (pending),
        .count          (count)
    );

    // On redirect, every grant still awaiting its response becomes a response to discard.
    always_comb begin
        drop_d = drop_q;
        if (FlushD) begin
            drop_d = drop_q + DROP_W'(pending) - DROP_W'(ImemRvalid);
        end else if (ImemRvalid && (drop_q != '0)) begin
            drop_d = drop_q - DROP_W'(1);
        end
    end

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pcp4_d  = pcp4_q;
        if (FlushD) begin
            valid_d = 1'b0;
            instr_d = RISC_NOP;
        end else if (!StallD) begin
            if (bypass_c) begin
                valid_d = 1'b1;
                instr_d = ImemRdata;
                pc_d    = head.pc;
                pcp4_d  = head.pc + 32'd4;
            end else if (head_rdy_c) begin
                valid_d = 1'b1;
                instr_d = head.instr;
                pc_d    = head.pc;
                pcp4_d  = head.pc + 32'd4;
            end else begin
                valid_d = 1'b0;
                instr_d = RISC_NOP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q  <= '0;
            valid_q <= 1'b0;
            instr_q <= RISC_NOP;
            pc_q    <= '0;
            pcp4_q  <= '0;
        end else begin
            drop_q  <= drop_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pcp4_q  <= pcp4_d;
        end
    end

    assign ValidD   = valid_q;
    assign InstrD   = instr_q;
    assign PCD      = pc_q;
    assign PCPlus4D = pcp4_q;

endmodule

// File: tb/tb_risc_fetch_queue.sv
// Directed bench for risc_fetch_queue with a PC register and an in-order fixed-latency memory model.
module tb_risc_fetch_queue;

`ifdef RISC_FETCH_BYPASS_EN
    localparam int LAT_D = 1;
`else
    localparam int LAT_D = 2;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] PCF;
    logic        FetchAdvF;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;
    logic        StallD;
    logic        FlushD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    int unsigned lat    = 1;
    logic [31:0] tgt    = '0;
    logic [31:0] q_addr [$];
    int unsigned q_due  [$];

    risc_fetch_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .PCF        (PCF),
        .FetchAdvF  (FetchAdvF),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemGnt    (ImemGnt),
        .ImemRvalid (ImemRvalid),
        .ImemRdata  (ImemRdata),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample pre-edge handshakes, then advance PC register and memory model.
    task automatic tick();
        logic        g;
        logic        adv;
        logic        f;
        logic [31:0] a;
        @(negedge clk);
        g   = ImemReq && ImemGnt;
        adv = FetchAdvF;
        f   = FlushD;
        a   = ImemAddr;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            PCF        = '0;
            ImemRvalid = 1'b0;
            ImemRdata  = '0;
            q_addr.delete();
            q_due.delete();
        end else begin
            if (g) begin
                q_addr.push_back(a);
                q_due.push_back(cyc - 1 + lat);
            end
            if (adv) PCF = f ? tgt : PCF + 32'd4;
            if (q_addr.size() > 0 && q_due[0] <= cyc) begin
                ImemRvalid = 1'b1;
                ImemRdata  = 32'hC000_0000 | q_addr[0];
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                ImemRvalid = 1'b0;
                ImemRdata  = '0;
            end
        end
        #1;
    endtask

    initial begin
        logic got;
        rst = 1'b1; PCF = '0; ImemGnt = 1'b0; ImemRvalid = 1'b0; ImemRdata = '0;
        StallD = 1'b0; FlushD = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", ValidD, 1'b0);
        chk("rst_instr", InstrD, 32'h0000_0013);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_pcp4", PCPlus4D, 32'h0);
        chk("rst_req", ImemReq, 1'b0);
        chk("rst_adv", FetchAdvF, 1'b0);

        // Stream from PC 0 with 1-cycle memory latency
        rst = 1'b0; ImemGnt = 1'b1; lat = 1; cyc = 0;
        #1;
        chk("c0_req", ImemReq, 1'b1);
        chk("c0_adv", FetchAdvF, 1'b1);
        chk("c0_addr", ImemAddr, 32'h0);
        repeat (LAT_D) tick();
        chk("pre_first_valid", ValidD, 1'b0);
        tick();
        chk("s0_valid", ValidD, 1'b1);
        chk("s0_instr", InstrD, 32'hC000_0000);
        chk("s0_pcd", PCD, 32'h0);
        chk("s0_pcp4", PCPlus4D, 32'h4);
        tick();
        chk("s1_instr", InstrD, 32'hC000_0004);
        chk("s1_pcd", PCD, 32'h4);
        chk("s1_pcp4", PCPlus4D, 32'h8);
        tick();
        chk("s2_pcd", PCD, 32'h8);
        chk("s2_pcp4", PCPlus4D, 32'hC);
        while (cyc < 6) tick();

        // Grant withheld for 5 cycles: PC must hold
        ImemGnt = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("nognt_adv", FetchAdvF, 1'b0);
            chk("nognt_req", ImemReq, 1'b1);
            chk("nognt_addr", ImemAddr, 32'h18);
            tick();
        end
        chk("drain_valid", ValidD, 1'b0);
        chk("drain_instr", InstrD, 32'h0000_0013);
        chk("drain_pcd", PCD, 32'h14);
        chk("drain_pcp4", PCPlus4D, 32'h18);

        // Decode stalled 8 cycles: four grants fill the queue, then requests stop
        StallD = 1'b1; ImemGnt = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("stall_fill_adv", FetchAdvF, 1'b1);
            chk("stall_fill_pcd", PCD, 32'h14);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            chk("stall_full_req", ImemReq, 1'b0);
            chk("stall_full_adv", FetchAdvF, 1'b0);
            chk("stall_full_addr", ImemAddr, 32'h28);
            chk("stall_full_valid", ValidD, 1'b0);
            chk("stall_full_pcd", PCD, 32'h14);
            tick();
        end
        StallD = 1'b0;
        tick();
        chk("unstall0_valid", ValidD, 1'b1);
        chk("unstall0_pcd", PCD, 32'h18);
        chk("unstall0_instr", InstrD, 32'hC000_0018);
        tick();
        chk("unstall1_pcd", PCD, 32'h1C);
        chk("unstall1_instr", InstrD, 32'hC000_001C);
        tick();
        chk("unstall2_pcd", PCD, 32'h20);
        tick();
        chk("unstall3_pcd", PCD, 32'h24);
        chk("unstall3_pcp4", PCPlus4D, 32'h28);
        ImemGnt = 1'b0;
        repeat (6) tick();
        chk("drain2_pcd", PCD, 32'h30);
        chk("drain2_valid", ValidD, 1'b0);

        // Flush with two grants in flight (latency 3, responses at flush+1 and +2)
        lat = 3; ImemGnt = 1'b1;
        tick();
        tick();
        FlushD = 1'b1; tgt = 32'h100;
        #1;
        chk("flush_req", ImemReq, 1'b0);
        chk("flush_adv", FetchAdvF, 1'b1);
        tick();
        FlushD = 1'b0;
        #1;
        chk("flush_addr", ImemAddr, 32'h100);
        for (int k = 0; k < 4; k++) begin
            chk("flush_bubble_valid", ValidD, 1'b0);
            chk("flush_bubble_instr", InstrD, 32'h0000_0013);
            chk("flush_bubble_pcd", PCD, 32'h30);
            if (k < 3) tick();
        end
        repeat (LAT_D) tick();
        chk("redirect_valid", ValidD, 1'b1);
        chk("redirect_pcd", PCD, 32'h100);
        chk("redirect_pcp4", PCPlus4D, 32'h104);
        chk("redirect_instr", InstrD, 32'hC000_0100);

        // Flush and stall in the same cycle
        FlushD = 1'b1; StallD = 1'b1; tgt = 32'h200;
        #1;
        chk("fs_req", ImemReq, 1'b0);
        chk("fs_adv", FetchAdvF, 1'b1);
        tick();
        FlushD = 1'b0; StallD = 1'b0;
        chk("fs_valid", ValidD, 1'b0);
        chk("fs_instr", InstrD, 32'h0000_0013);
        chk("fs_pcd", PCD, 32'h100);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (ValidD === 1'b1) got = 1'b1;
        end
        chk("fs_wait_valid", 32'(got), 32'h1);
        chk("fs_first_pcd", PCD, 32'h200);
        chk("fs_first_instr", InstrD, 32'hC000_0200);
        tick();

        // Asynchronous reset in mid-stream
        rst = 1'b1;
        PCF = '0; ImemRvalid = 1'b0; ImemRdata = '0;
        q_addr.delete(); q_due.delete();
        #1;
        chk("arst_valid", ValidD, 1'b0);
        chk("arst_instr", InstrD, 32'h0000_0013);
        chk("arst_pcd", PCD, 32'h0);
        chk("arst_pcp4", PCPlus4D, 32'h0);
        chk("arst_req", ImemReq, 1'b0);
        chk("arst_adv", FetchAdvF, 1'b0);
        tick();
        rst = 1'b0; lat = 1;
        #1;
        chk("restart_req", ImemReq, 1'b1);
        chk("restart_addr", ImemAddr, 32'h0);
        repeat (LAT_D + 1) tick();
        chk("restart_valid", ValidD, 1'b1);
        chk("restart_pcd", PCD, 32'h0);
        chk("restart_instr", InstrD, 32'hC000_0000);
        tick();
        chk("restart_pcd1", PCD, 32'h4);
        chk("restart_pcp4_1", PCPlus4D, 32'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
